// File: rtl/calc_key_ctrl.sv
// calc_key_ctrl
// Keypad sequencing controller for the calculator LCD picture generator.
// It turns single-cycle navigation/select pulses into a 4x4 keypad cursor and
// a 16-character input string. On '=' it evaluates the string left to right,
// one character per cycle, with a shift-add multiplier for '*'.
//
// Ports:
//   clk_in          system clock
//   sys_rst         synchronous active-high reset
//   btn_up/down/left/right  single-cycle cursor move pulses
//   btn_sel         single-cycle pulse, activates the key under the cursor
//   cursor_x/_y     cursor column/row, 0..3
//   disp_str_flat   input string, char k at bits [k*8+:8], unused = 0x20
//   result          last evaluation result (unsigned)
//   calc_done       high while result is valid
//   busy            high while evaluation is in progress
module calc_key_ctrl #(
  parameter int MAX_LEN = 16,
  parameter int RES_W   = 24
) (
  input  logic                 clk_in,
  input  logic                 sys_rst,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_sel,
  output logic [3:0]           cursor_x,
  output logic [3:0]           cursor_y,
  output logic [MAX_LEN*8-1:0] disp_str_flat,
  output logic [RES_W-1:0]     result,
  output logic                 calc_done,
  output logic                 busy
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int CNT_W = $clog2(RES_W);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(RES_W - 1);

  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_CLR   = 8'h43;
  localparam logic [7:0] CH_BS    = 8'h42;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Keypad legend; C, = and B are internal codes and never stored in the string.
  function automatic logic [7:0] key_at(input logic [1:0] row, input logic [1:0] col);
    logic [7:0] k;
    case ({row, col})
      4'd0:    k = 8'h31;
      4'd1:    k = 8'h32;
      4'd2:    k = 8'h33;
      4'd3:    k = CH_PLUS;
      4'd4:    k = 8'h34;
      4'd5:    k = 8'h35;
      4'd6:    k = 8'h36;
      4'd7:    k = CH_MINUS;
      4'd8:    k = 8'h37;
      4'd9:    k = 8'h38;
      4'd10:   k = 8'h39;
      4'd11:   k = CH_MUL;
      4'd12:   k = CH_CLR;
      4'd13:   k = 8'h30;
      4'd14:   k = CH_EQ;
      4'd15:   k = CH_BS;
      default: k = CH_SP;
    endcase
    return k;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == CH_PLUS) || (c == CH_MINUS) || (c == CH_MUL);
  endfunction

  state_t                  state, state_nx;
  logic [1:0]              cur_x, cur_x_nx, cur_y, cur_y_nx;
  logic [MAX_LEN-1:0][7:0] str, str_nx;
  logic [LEN_W-1:0]        len, len_nx, idx, idx_nx;
  logic [RES_W-1:0]        acc, acc_nx, opnd, opnd_nx;
  logic [RES_W-1:0]        mcand, mcand_nx, mplier, mplier_nx, prod, prod_nx;
  logic [RES_W-1:0]        result_nx;
  logic [7:0]              pend_op, pend_op_nx;
  logic [CNT_W-1:0]        mul_cnt, mul_cnt_nx;
  logic                    calc_done_nx, busy_nx;

  logic [7:0]              key, last_ch, cur_ch;
  logic [LEN_W-1:0]        len_m1;
  logic                    at_end, edit_ok, accepted, apply_done;
  logic [RES_W-1:0]        apply_val, mul_sum;

  assign cursor_x      = {2'b00, cur_x};
  assign cursor_y      = {2'b00, cur_y};
  assign disp_str_flat = str;

  // Next-state, cursor, edit and evaluation datapath.
  always_comb begin
    state_nx     = state;
    cur_x_nx     = cur_x;
    cur_y_nx     = cur_y;
    str_nx       = str;
    len_nx       = len;
    idx_nx       = idx;
    acc_nx       = acc;
    opnd_nx      = opnd;
    mcand_nx     = mcand;
    mplier_nx    = mplier;
    prod_nx      = prod;
    pend_op_nx   = pend_op;
    mul_cnt_nx   = mul_cnt;
    result_nx    = result;
    calc_done_nx = calc_done;
    busy_nx      = busy;
    accepted     = 1'b0;
    apply_done   = 1'b0;
    apply_val    = acc;
    mul_sum      = prod;

    key     = key_at(cur_y, cur_x);
    len_m1  = len - LEN_W'(1);
    last_ch = (len != {LEN_W{1'b0}}) ? str[len_m1[IDX_W-1:0]] : CH_SP;
    // idx == len marks the virtual end-of-string terminator.
    at_end  = (idx == len);
    cur_ch  = at_end ? CH_SP : str[idx[IDX_W-1:0]];
    edit_ok = (state == IDLE) || (state == DONE);

    // One pulse per cycle wins; sel suppresses moves even when it is ignored.
    if (btn_sel) begin
      if (edit_ok) begin
        if (is_digit(key)) begin
          if (len < LEN_MAX) begin
            str_nx[len[IDX_W-1:0]] = key;
            len_nx   = len + LEN_W'(1);
            accepted = 1'b1;
          end else begin
            accepted = 1'b0;
          end
        end else if (is_op(key)) begin
          if ((len != {LEN_W{1'b0}}) && (len < LEN_MAX) && is_digit(last_ch)) begin
            str_nx[len[IDX_W-1:0]] = key;
            len_nx   = len + LEN_W'(1);
            accepted = 1'b1;
          end else begin
            accepted = 1'b0;
          end
        end else if (key == CH_BS) begin
          if (len != {LEN_W{1'b0}}) begin
            str_nx[len_m1[IDX_W-1:0]] = CH_SP;
            len_nx   = len_m1;
            accepted = 1'b1;
          end else begin
            accepted = 1'b0;
          end
        end else if (key == CH_CLR) begin
          str_nx   = {MAX_LEN{CH_SP}};
          len_nx   = {LEN_W{1'b0}};
          accepted = 1'b1;
        end else if ((key == CH_EQ) && (state == IDLE) && (len != {LEN_W{1'b0}})) begin
          state_nx   = EVAL;
          busy_nx    = 1'b1;
          idx_nx     = {LEN_W{1'b0}};
          acc_nx     = {RES_W{1'b0}};
          opnd_nx    = {RES_W{1'b0}};
          pend_op_nx = CH_PLUS;
        end else begin
          accepted = 1'b0;
        end
        // A successful edit invalidates the shown result but keeps its value.
        if (accepted && (state == DONE)) begin
          state_nx     = IDLE;
          calc_done_nx = 1'b0;
        end else begin
          calc_done_nx = calc_done_nx;
        end
      end else begin
        accepted = 1'b0;
      end
    end else if (btn_up) begin
      cur_y_nx = cur_y - 2'd1;
    end else if (btn_down) begin
      cur_y_nx = cur_y + 2'd1;
    end else if (btn_left) begin
      cur_x_nx = cur_x - 2'd1;
    end else if (btn_right) begin
      cur_x_nx = cur_x + 2'd1;
    end else begin
      cur_x_nx = cur_x;
    end

    case (state)
      EVAL: begin
        if (!at_end && is_digit(cur_ch)) begin
          opnd_nx = (opnd << 3) + (opnd << 1) + RES_W'(cur_ch[3:0]);
          idx_nx  = idx + LEN_W'(1);
        end else if (pend_op == CH_MUL) begin
          // Multiply is deferred to MUL; idx stays on this operator/terminator.
          mcand_nx   = acc;
          mplier_nx  = opnd;
          prod_nx    = {RES_W{1'b0}};
          mul_cnt_nx = {CNT_W{1'b0}};
          state_nx   = MUL;
        end else if (pend_op == CH_MINUS) begin
          apply_done = 1'b1;
          apply_val  = (opnd > acc) ? {RES_W{1'b0}} : (acc - opnd);
        end else begin
          apply_done = 1'b1;
          apply_val  = acc + opnd;
        end
      end
      MUL: begin
        mul_sum    = prod + (mplier[0] ? mcand : {RES_W{1'b0}});
        prod_nx    = mul_sum;
        mcand_nx   = mcand << 1;
        mplier_nx  = mplier >> 1;
        mul_cnt_nx = mul_cnt + CNT_W'(1);
        // The last bit finishes the apply here so '*' costs exactly RES_W cycles.
        if (mul_cnt == MUL_LAST) begin
          apply_done = 1'b1;
          apply_val  = mul_sum;
        end else begin
          apply_done = 1'b0;
        end
      end
      IDLE:    state_nx = state_nx;
      DONE:    state_nx = state_nx;
      default: state_nx = IDLE;
    endcase

    // Common tail of an operator apply: latch the accumulator, then either
    // finish or adopt the operator at idx as the pending one.
    if (apply_done) begin
      acc_nx  = apply_val;
      opnd_nx = {RES_W{1'b0}};
      if (at_end) begin
        result_nx    = apply_val;
        state_nx     = DONE;
        busy_nx      = 1'b0;
        calc_done_nx = 1'b1;
      end else begin
        pend_op_nx = cur_ch;
        idx_nx     = idx + LEN_W'(1);
        state_nx   = EVAL;
      end
    end else begin
      acc_nx = acc_nx;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      state     <= IDLE;
      cur_x     <= 2'd0;
      cur_y     <= 2'd0;
      str       <= {MAX_LEN{CH_SP}};
      len       <= {LEN_W{1'b0}};
      idx       <= {LEN_W{1'b0}};
      acc       <= {RES_W{1'b0}};
      opnd      <= {RES_W{1'b0}};
      mcand     <= {RES_W{1'b0}};
      mplier    <= {RES_W{1'b0}};
      prod      <= {RES_W{1'b0}};
      pend_op   <= CH_PLUS;
      mul_cnt   <= {CNT_W{1'b0}};
      result    <= {RES_W{1'b0}};
      calc_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cur_x     <= cur_x_nx;
      cur_y     <= cur_y_nx;
      str       <= str_nx;
      len       <= len_nx;
      idx       <= idx_nx;
      acc       <= acc_nx;
      opnd      <= opnd_nx;
      mcand     <= mcand_nx;
      mplier    <= mplier_nx;
      prod      <= prod_nx;
      pend_op   <= pend_op_nx;
      mul_cnt   <= mul_cnt_nx;
      result    <= result_nx;
      calc_done <= calc_done_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_calc_key_ctrl.sv
module tb_calc_key_ctrl;

  logic         clk_in = 1'b0;
  logic         sys_rst;
  logic         btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [3:0]   cursor_x, cursor_y;
  logic [127:0] disp_str_flat;
  logic [23:0]  result;
  logic         calc_done, busy;

  int checks = 0;
  int errors = 0;
  int tb_x   = 0;
  int tb_y   = 0;
  int cyc;

  localparam logic [4:0] B_S = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_R = 5'b00001;

  typedef struct {
    logic [4:0] btn;   // {sel, up, down, left, right}
    logic [3:0] ex;
    logic [3:0] ey;
  } vec_t;

  vec_t vecs [13];

  calc_key_ctrl #(.MAX_LEN(16), .RES_W(24)) dut (
    .clk_in(clk_in), .sys_rst(sys_rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_sel(btn_sel),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .disp_str_flat(disp_str_flat), .result(result),
    .calc_done(calc_done), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_str(input string s);
    logic [127:0] r;
    r = {16{8'h20}};
    for (int i = 0; i < s.len(); i++) r[i*8 +: 8] = s[i];
    return r;
  endfunction

  // One-cycle pulse; returns on the falling edge after the sampling edge.
  task automatic pulse(input logic [4:0] b);
    @(negedge clk_in);
    {btn_sel, btn_up, btn_down, btn_left, btn_right} = b;
    @(negedge clk_in);
    {btn_sel, btn_up, btn_down, btn_left, btn_right} = 5'b00000;
  endtask

  task automatic key_pos(input byte c, output int r, output int col);
    case (c)
      "1": begin r = 0; col = 0; end
      "2": begin r = 0; col = 1; end
      "3": begin r = 0; col = 2; end
      "+": begin r = 0; col = 3; end
      "4": begin r = 1; col = 0; end
      "5": begin r = 1; col = 1; end
      "6": begin r = 1; col = 2; end
      "-": begin r = 1; col = 3; end
      "7": begin r = 2; col = 0; end
      "8": begin r = 2; col = 1; end
      "9": begin r = 2; col = 2; end
      "*": begin r = 2; col = 3; end
      "C": begin r = 3; col = 0; end
      "0": begin r = 3; col = 1; end
      "=": begin r = 3; col = 2; end
      default: begin r = 3; col = 3; end
    endcase
  endtask

  task automatic press_key(input byte c);
    int r, col;
    key_pos(c, r, col);
    while (tb_x != col) begin pulse(B_R); tb_x = (tb_x + 1) % 4; end
    while (tb_y != r)   begin pulse(B_D); tb_y = (tb_y + 1) % 4; end
    pulse(B_S);
  endtask

  task automatic enter(input string s);
    for (int i = 0; i < s.len(); i++) press_key(s[i]);
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (busy === 1'b1 && n < bound) begin
      @(negedge clk_in);
      n++;
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    {btn_sel, btn_up, btn_down, btn_left, btn_right} = 5'b00000;
    vecs[0]  = '{B_R,       4'd1, 4'd0};
    vecs[1]  = '{B_R,       4'd2, 4'd0};
    vecs[2]  = '{B_R,       4'd3, 4'd0};
    vecs[3]  = '{B_R,       4'd0, 4'd0};
    vecs[4]  = '{B_U,       4'd0, 4'd3};
    vecs[5]  = '{B_D,       4'd0, 4'd0};
    vecs[6]  = '{B_L,       4'd3, 4'd0};
    vecs[7]  = '{B_U | B_D, 4'd3, 4'd3};
    vecs[8]  = '{B_L | B_R, 4'd2, 4'd3};
    vecs[9]  = '{B_D | B_L, 4'd2, 4'd0};
    vecs[10] = '{5'b00000,  4'd2, 4'd0};
    vecs[11] = '{B_R,       4'd3, 4'd0};
    vecs[12] = '{B_S | B_U, 4'd3, 4'd0};  // '+' on empty string, up dropped

    repeat (2) @(negedge clk_in);
    sys_rst = 1'b0;
    chk("rst_cursor", {cursor_y, cursor_x}, 8'h00);
    chk("rst_str", disp_str_flat, mk_str(""));
    chk("rst_result", result, 24'd0);
    chk("rst_busy_done", {busy, calc_done}, 2'b00);

    for (int i = 0; i < 13; i++) begin
      pulse(vecs[i].btn);
      chk($sformatf("cursor_vec%0d", i), {cursor_y, cursor_x}, {vecs[i].ey, vecs[i].ex});
    end
    chk("plus_on_empty", disp_str_flat, mk_str(""));
    tb_x = 3; tb_y = 0;

    enter("12+3");
    chk("str_12p3", disp_str_flat, mk_str("12+3"));
    chk("idle_flags", {busy, calc_done}, 2'b00);
    press_key("=");
    chk("busy_rise", {busy, calc_done}, 2'b10);
    wait_done(20, cyc);
    chk("lat_12p3", cyc, 5);
    chk("done_12p3", {busy, calc_done}, 2'b01);
    chk("res_12p3", result, 24'd15);

    press_key("C");
    chk("clr_done", calc_done, 1'b0);
    chk("clr_str", disp_str_flat, mk_str(""));
    chk("clr_res_hold", result, 24'd15);

    enter("12*34-8=");
    wait_done(50, cyc);
    chk("lat_mul", cyc, 32);
    chk("res_mul", result, 24'd400);

    press_key("C");
    enter("3-5=");
    wait_done(20, cyc);
    chk("lat_clamp", cyc, 4);
    chk("res_clamp", result, 24'd0);
    chk("done_clamp", calc_done, 1'b1);
    press_key("4");
    chk("edit_drops_done", calc_done, 1'b0);
    chk("str_3m54", disp_str_flat, mk_str("3-54"));
    chk("res_hold", result, 24'd0);

    press_key("C");
    press_key("+");
    chk("plus_empty2", disp_str_flat, mk_str(""));
    enter("12345678901234567");
    chk("str_full", disp_str_flat, mk_str("1234567890123456"));
    press_key("+");
    chk("op_when_full", disp_str_flat, mk_str("1234567890123456"));
    press_key("B");
    chk("backspace", disp_str_flat, mk_str("123456789012345"));

    press_key("C");
    enter("1+");
    press_key("*");
    chk("op_after_op", disp_str_flat, mk_str("1+"));
    enter("2*3=");
    wait_done(50, cyc);
    chk("lat_l2r", cyc, 30);
    chk("res_l2r", result, 24'd9);
    press_key("=");
    chk("eq_in_done", {busy, calc_done}, 2'b01);
    press_key("B");
    chk("bs_in_done", calc_done, 1'b0);
    chk("bs_str", disp_str_flat, mk_str("1+2*"));

    press_key("C");
    enter("2*3=");
    repeat (6) @(negedge clk_in);
    chk("in_mul", busy, 1'b1);
    sys_rst = 1'b1;
    @(negedge clk_in);
    sys_rst = 1'b0;
    chk("abort_flags", {busy, calc_done}, 2'b00);
    chk("abort_str", disp_str_flat, mk_str(""));
    chk("abort_cursor", {cursor_y, cursor_x}, 8'h00);
    chk("abort_result", result, 24'd0);
    tb_x = 0; tb_y = 0;
    pulse(B_S | B_U);
    chk("sel_up_str", disp_str_flat, mk_str("1"));
    chk("sel_up_cursor", {cursor_y, cursor_x}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_key_ctrl.md
Name: calc_key_ctrl

Overview:
Sequencing controller for the calculator LCD picture generator. It turns single-cycle navigation and select pulses into the 4x4 keypad cursor position and the 16-character input string. On '=' it runs a multi-cycle, left-to-right evaluation of the string and presents result and calc_done for the display. It sits between the debounced button front-end and the LCD pixel generator.

Parameters:
MAX_LEN, 16, maximum characters in the input string (fixed to match the 128-bit display bus).
RES_W, 24, width of the operand accumulator and the result.

Ports:
clk_in  input  1  system clock; the block uses this single clock.
sys_rst  input  1  reset, synchronous and active-high.
btn_up  input  1  single-cycle pulse; move cursor up.
btn_down  input  1  single-cycle pulse; move cursor down.
btn_left  input  1  single-cycle pulse; move cursor left.
btn_right  input  1  single-cycle pulse; move cursor right.
btn_sel  input  1  single-cycle pulse; activate the key under the cursor.
cursor_x  output  4  cursor column, 0..3.
cursor_y  output  4  cursor row, 0..3.
disp_str_flat  output  128  input string; char k occupies bits [k*8+:8]; unused positions hold 0x20.
result  output  RES_W  evaluation result, unsigned.
calc_done  output  1  high while result is valid.
busy  output  1  high while evaluation is in progress.

Behaviour:
- Reset (sys_rst=1 at a clk_in edge):
  - cursor=(0,0), all chars 0x20, len=0, result=0, calc_done=0, busy=0, FSM=IDLE.
  - Reset applied during evaluation aborts it at that same edge.
- Key map by (row=cursor_y, col=cursor_x):
  - row 0: 1 2 3 +
  - row 1: 4 5 6 -
  - row 2: 7 8 9 *
  - row 3: C 0 = B (B = backspace)
- Same-cycle pulses: only one is processed, priority sel > up > down > left > right; the others are dropped.
- Cursor:
  - Each move pulse wraps modulo 4 on its axis (e.g. left at x=0 gives x=3).
  - Cursor moves are accepted in every state, including EVAL.
  - Cursor output updates at the edge after the pulse.
- Edits (IDLE or DONE only; 1-cycle latency to disp_str_flat):
  - Digit: appended at position len if len<16; otherwise ignored.
  - Operator: appended only if len>0, len<16 and the last char is a digit; otherwise ignored.
  - B: if len>0, the last char becomes 0x20 and len decrements.
  - C: clears all chars and sets len=0.
  - Any digit, operator, B or C accepted in DONE drops calc_done to 0 and returns to IDLE. result holds its value.
- FSM states: IDLE, EVAL, MUL, DONE.
  - IDLE, '=' with len>0: go to EVAL, busy=1, idx=0, acc=0, opnd=0, pend_op='+'.
  - IDLE, '=' with len=0: ignored.
  - EVAL, one char per cycle at idx:
    - Digit: opnd = opnd*10 + digit, truncated to RES_W.
    - Operator, or idx==len: apply pend_op to (acc, opnd).
    - '+': acc = (acc+opnd) mod 2^RES_W.
    - '-': acc = acc-opnd, clamped to 0 if opnd>acc.
    - '*': go to MUL.
    - After applying, the operator at idx becomes pend_op and opnd=0.
    - When idx==len and the final apply completes: result=acc, go to DONE.
  - MUL: shift-add over RES_W cycles (one bit per cycle). Product is truncated to RES_W. Then return to EVAL with the same idx.
  - DONE: calc_done=1, busy=0.
    - '=' is ignored.
    - Edit keys behave as above.
- During EVAL and MUL, all sel pulses are ignored and the string is frozen.
- Evaluation is strictly left-to-right with no precedence.
- Timing:
  - Evaluation latency = len+1 cycles for EVAL, plus RES_W cycles for each '*'.
  - calc_done rises at the same edge busy falls.

Test Plan:
- Reset, then right,right,right → cursor_x=3; right once more → 0; up from y=0 → cursor_y=3.
- Enter 1,2,+,3 then '=' → disp_str_flat chars "12+3"; after 5 cycles busy=0, calc_done=1, result=15.
- Enter "12*34-8" then '=' → result=400; busy holds for 8+24 cycles.
- "3-5=" → result=0 (clamp). Then press '4' → calc_done=0, string "3-54", result still 0.
- Select '+' on an empty string → ignored. 17 digits → len=16 and the 17th is dropped. Then B → char 15 = 0x20.
- Assert sys_rst mid-MUL → next cycle busy=0, calc_done=0, string all 0x20, cursor=(0,0). btn_sel together with btn_up in the same cycle → only the sel is applied.
